seven_seg_reader: RTL
=====================

# seven_seg_reader

Decodes a multiplexed, active-low seven-segment display bus (segment lines plus per-digit anode enables) back into 4-bit digit values. It sits on the display side of the Pong score path. It captures each digit only after its pattern has been stable for a configurable number of cycles, then publishes a complete frame with a one-cycle valid pulse. It is used for on-chip score readback and display self-check.

## Interface
- DIGITS, 4, number of multiplexed digits (2..8)
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (2..255)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- segments  in  7  active-low segment lines; segments[0]=a, [1]=b, … [6]=g
- anodes  in  DIGITS  active-low digit enables; anodes[i]=0 selects digit i
- digits  out  4*DIGITS  decoded values; digit i at [4i+3:4i]
- blank  out  DIGITS  digit i showed all segments off in the last published frame
- err  out  1  last published frame contained an undecodable pattern or a multi-anode sample
- frame_valid  out  1  one-cycle pulse; digits/blank/err updated on the same edge

## Operation
- Input stage: {anodes, segments} registered once per clk (sample register).
- Stability counter: increments, saturating at STABLE_CYCLES, while the current sample equals the previous one. Reloads to 1 on any change.
- Capture event: occurs on the edge where the counter first reaches STABLE_CYCLES. Fires exactly once per stable window.
- At a capture event:
  - Exactly one anode low: decode into shadow slot i and set seen[i].
  - All anodes high: ignored.
  - More than one anode low: set frame_err and do not write a slot.
- Decode (active-low hex of segments):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:18
  - 7F: value 4'hF, blank bit set
  - Any other pattern: value 4'hE, frame_err set
- FSM:
  - HUNT: wait for a capture of digit 0, then go to COLLECT with seen = 0…01 and frame_err from that capture.
  - COLLECT: accumulate captures. When seen is all ones, go to PUBLISH.
  - PUBLISH (one cycle):
    - digits ← shadow, blank ← shadow blank bits, err ← frame_err, frame_valid = 1.
    - Clear seen and frame_err, then go to HUNT.
- A recapture of an already-seen digit in COLLECT overwrites its slot; the newest value wins.

## Timing
- Reset values: digits=0, blank=0, err=0, frame_valid=0, FSM=HUNT, seen=0, counter=0, sample register=all ones.
- Input-to-capture latency: a pattern presented before edge k and held is captured at edge k+STABLE_CYCLES-1.
- Capture of the last digit to frame_valid: 1 cycle (the PUBLISH state).
- Captures that would occur in the PUBLISH cycle are dropped.
- digits/blank/err hold between frames.
- A pattern held indefinitely yields only one capture.
- A change that lasts less than STABLE_CYCLES samples (glitch) yields no capture and restarts the count.
- Reset asserted mid-frame discards the shadow registers and seen. The outputs return to their reset values on the next edge.

## Configuration
- SEVEN_SEG_READER_STRICT_ORDER_EN:
  - Defined: in COLLECT, each capture must be digit popcount(seen), i.e. ascending 0..DIGITS-1. An out-of-order capture abandons the frame and returns to HUNT without publishing. A capture of digit 0 restarts the frame instead.
  - Undefined: captures are accepted in any order, and the frame completes when every digit has been seen.

## Test plan
- Scan 4 digits (anodes E,D,B,7) showing 1,2,3,4 (79,24,30,19), each held 8 cycles → frame_valid pulse once; digits=16'h4321, blank=0, err=0.
- Hold digit 0 at 40 for 3 cycles, then change, with STABLE_CYCLES=4 → no capture, FSM stays in HUNT, no frame_valid.
- Scan with digit 2 at 7F and digit 3 at 55 → digits[11:8]=F, blank=4'b0100, digits[15:12]=E, err=1.
- Sample with anodes=4'b1100 mid-frame, then a normal scan → published err=1; a following clean frame gives err=0.
- Assert reset during COLLECT after two digits → next cycle all outputs 0; a later full scan publishes normally.
- Scan order 0,2,1,3 → with STRICT_ORDER_EN no frame_valid until an in-order scan; without it, frame_valid with correct digits.

Source files
------------

// File: rtl/seven_seg_reader.sv
// seven_seg_reader: recovers 4-bit digit values from a multiplexed, active-low
// seven-segment bus. Each digit is captured once its {anodes, segments} sample
// has been stable for STABLE_CYCLES samples. When every digit has been seen,
// the frame is published with a one-cycle frame_valid pulse.
//
// Optional build macro: SEVEN_SEG_READER_STRICT_ORDER_EN
//   Defined   - digits must arrive in ascending order 0..DIGITS-1. An
//               out-of-order digit abandons the frame. A new digit 0
//               restarts the frame.
//   Undefined - digits may arrive in any order.
module seven_seg_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            segments,
    input  logic [DIGITS-1:0]     anodes,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     blank,
    output logic                  err,
    output logic                  frame_valid
);

    localparam int BUS_W = DIGITS + 7;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ARM  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [DIGITS-1:0] ALL_SEEN = {DIGITS{1'b1}};
    localparam logic [DIGITS-1:0] SEEN_D0  = DIGITS'(1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        COLLECT = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    // Active-low hex decode. Result is {bad, blank, value[3:0]}.
    function automatic logic [5:0] decode_seg(input logic [6:0] seg);
        logic [5:0] r;
        case (seg)
            7'h40:   r = {2'b00, 4'h0};
            7'h79:   r = {2'b00, 4'h1};
            7'h24:   r = {2'b00, 4'h2};
            7'h30:   r = {2'b00, 4'h3};
            7'h19:   r = {2'b00, 4'h4};
            7'h12:   r = {2'b00, 4'h5};
            7'h02:   r = {2'b00, 4'h6};
            7'h78:   r = {2'b00, 4'h7};
            7'h00:   r = {2'b00, 4'h8};
            7'h18:   r = {2'b00, 4'h9};
            7'h7F:   r = {2'b01, 4'hF};
            default: r = {2'b10, 4'hE};
        endcase
        return r;
    endfunction

    // Index of the active digit. Only meaningful when exactly one bit is set.
    function automatic logic [IDX_W-1:0] low_index(input logic [DIGITS-1:0] low);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (low[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // True when exactly one bit of the vector is set.
    function automatic logic is_onehot(input logic [DIGITS-1:0] v);
        return (v != '0) && ((v & (v - DIGITS'(1))) == '0);
    endfunction

`ifdef SEVEN_SEG_READER_STRICT_ORDER_EN
    // Number of digits already collected; it is the next digit expected.
    function automatic logic [7:0] popcnt(input logic [DIGITS-1:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < DIGITS; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction
`endif

    logic [BUS_W-1:0]    bus_in;
    logic [BUS_W-1:0]    sample_p0;
    logic [CNT_W-1:0]    cnt_p0;
    logic                same;
    logic                cap_vld;
    logic [DIGITS-1:0]   cap_low;
    logic [6:0]          cap_seg;
    logic                cap_one;
    logic                cap_multi;
    logic [IDX_W-1:0]    cap_idx;
    logic [5:0]          cap_dec;
    logic                cap_bad;

    state_t              state;
    state_t              state_nxt;
    logic [DIGITS-1:0]   seen;
    logic [DIGITS-1:0]   seen_nxt;
    logic                frame_err;
    logic                ferr_nxt;
    logic                wr_en;
    logic                publish;

    logic [4*DIGITS-1:0] shadow_dig;
    logic [DIGITS-1:0]   shadow_blank;

    // A capture is qualified by the sample currently being taken. A capture
    // only fires when that sample equals the held one, so the held sample is
    // the pattern that is captured.
    assign bus_in    = {anodes, segments};
    assign same      = (bus_in == sample_p0);
    assign cap_vld   = same && (cnt_p0 == CNT_ARM);
    assign cap_low   = ~sample_p0[BUS_W-1:7];
    assign cap_seg   = sample_p0[6:0];
    assign cap_one   = is_onehot(cap_low);
    assign cap_multi = (cap_low != '0) && !cap_one;
    assign cap_idx   = low_index(cap_low);
    assign cap_dec   = decode_seg(cap_seg);
    assign cap_bad   = cap_dec[5];

    // Input sample register and saturating stability counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_p0 <= '1;
            cnt_p0    <= '0;
        end else begin
            sample_p0 <= bus_in;
            if (!same) begin
                cnt_p0 <= CNT_ONE;
            end else if (cnt_p0 != CNT_MAX) begin
                cnt_p0 <= cnt_p0 + CNT_ONE;
            end
        end
    end

    // Frame FSM state, seen mask and accumulated frame error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HUNT;
            seen      <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            seen      <= seen_nxt;
            frame_err <= ferr_nxt;
        end
    end

    // Next-state logic: decides which captures land in the shadow frame.
    always_comb begin
        state_nxt = state;
        seen_nxt  = seen;
        ferr_nxt  = frame_err;
        wr_en     = 1'b0;
        publish   = 1'b0;
        case (state)
            HUNT: begin
                if (cap_vld && cap_one && (cap_idx == '0)) begin
                    state_nxt = COLLECT;
                    seen_nxt  = SEEN_D0;
                    ferr_nxt  = cap_bad;
                    wr_en     = 1'b1;
                end
            end
            COLLECT: begin
                if (cap_vld) begin
                    if (cap_multi) begin
                        ferr_nxt = 1'b1;
                    end else if (cap_one) begin
`ifdef SEVEN_SEG_READER_STRICT_ORDER_EN
                        if (8'(cap_idx) == popcnt(seen)) begin
                            seen_nxt = seen | (SEEN_D0 << cap_idx);
                            ferr_nxt = frame_err | cap_bad;
                            wr_en    = 1'b1;
                        end else if (cap_idx == '0) begin
                            seen_nxt = SEEN_D0;
                            ferr_nxt = cap_bad;
                            wr_en    = 1'b1;
                        end else begin
                            state_nxt = HUNT;
                            seen_nxt  = '0;
                            ferr_nxt  = 1'b0;
                        end
`else
                        seen_nxt = seen | (SEEN_D0 << cap_idx);
                        ferr_nxt = frame_err | cap_bad;
                        wr_en    = 1'b1;
`endif
                    end
                end
                if (state_nxt == COLLECT && seen_nxt == ALL_SEEN) begin
                    state_nxt = PUBLISH;
                end
            end
            PUBLISH: begin
                publish   = 1'b1;
                state_nxt = HUNT;
                seen_nxt  = '0;
                ferr_nxt  = 1'b0;
            end
            default: begin
                state_nxt = HUNT;
                seen_nxt  = '0;
                ferr_nxt  = 1'b0;
            end
        endcase
    end

    // Shadow frame slots; seen gates their use, so they need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            shadow_dig[4*cap_idx +: 4] <= cap_dec[3:0];
            shadow_blank[cap_idx]      <= cap_dec[4];
        end
    end

    // Published outputs; they hold between frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            digits      <= '0;
            blank       <= '0;
            err         <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= publish;
            if (publish) begin
                digits <= shadow_dig;
                blank  <= shadow_blank;
                err    <= frame_err;
            end
        end
    end

endmodule
